// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared state type and constants for the memory arbiter
// Revision 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_MERGE = 1'b1
    } state_t;

    localparam int         DEF_MEM_ADDR_BITS = 20;
    localparam logic [3:0] BE_FULL           = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_rr_arb.sv
`default_nettype none
// ============================================================================
// mem_rr_arb : 2-way round-robin grant, instruction vs data requester
// Revision 1.0
// ============================================================================
module mem_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_inst,
    input  logic req_data,
    output logic gnt_inst,
    output logic gnt_data
);

    // Set when the data port was granted most recently; reset value makes
    // the instruction port win the first tie.
    logic r_last_data;

    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (en) begin
            if (req_inst && req_data) begin
                gnt_inst = r_last_data;
                gnt_data = !r_last_data;
            end else begin
                gnt_inst = req_inst;
                gnt_data = req_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= 1'b1;
        end else if (gnt_inst) begin
            r_last_data <= 1'b0;
        end else if (gnt_data) begin
            r_last_data <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : instruction/data port arbiter onto one word memory with RMW
// Revision 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_i_bad;
    logic        w_d_bad;
    logic        w_d_partial;
    logic [31:0] w_merged;
    logic [31:0] r_rmw_addr;
    logic [31:0] r_rmw_wdata;
    logic [3:0]  r_rmw_be;
    logic        r_i_rvalid;
    logic        r_i_err;
    logic        r_i_rd;
    logic        r_d_rvalid;
    logic        r_d_err;
    logic        r_d_rd;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> MEM_ADDR_BITS) != 32'd0);
    endfunction

    assign w_i_bad     = addr_bad(i_addr);
    assign w_d_bad     = addr_bad(d_addr);
    assign w_d_partial = d_we && !w_d_bad && (d_be != 4'h0) && (d_be != BE_FULL);

    // Gating with rst_n keeps grants low while reset is held.
    mem_rr_arb u_rr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       ((r_state == IDLE) && rst_n),
        .req_inst (i_req),
        .req_data (d_req),
        .gnt_inst (w_gnt_i),
        .gnt_data (w_gnt_d)
    );

    assign i_gnt = w_gnt_i;
    assign d_gnt = w_gnt_d;

    always_comb begin
        w_merged = m_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_rmw_be[b]) begin
                w_merged[8*b +: 8] = r_rmw_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        if (r_state == RMW_MERGE) begin
            m_we        = 1'b1;
            m_addr      = r_rmw_addr;
            m_wdata     = w_merged;
            w_state_nxt = IDLE;
        end else if (w_gnt_i) begin
            m_addr = i_addr;
        end else if (w_gnt_d) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we && !w_d_bad && (d_be == BE_FULL);
            if (w_d_partial) begin
                w_state_nxt = RMW_MERGE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A partial write answers from the merge cycle, never from its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rvalid  <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rd      <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rd      <= 1'b0;
            r_rmw_addr  <= '0;
            r_rmw_wdata <= '0;
            r_rmw_be    <= '0;
        end else begin
            r_i_rvalid <= w_gnt_i;
            r_i_err    <= w_gnt_i && w_i_bad;
            r_i_rd     <= w_gnt_i && !w_i_bad;
            r_d_rvalid <= (w_gnt_d && !w_d_partial) || (r_state == RMW_MERGE);
            r_d_err    <= w_gnt_d && w_d_bad;
            r_d_rd     <= w_gnt_d && !d_we && !w_d_bad;
            if (w_gnt_d && w_d_partial) begin
                r_rmw_addr  <= d_addr;
                r_rmw_wdata <= d_wdata;
                r_rmw_be    <= d_be;
            end
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign i_err    = r_i_err;
    assign i_rdata  = r_i_rd ? m_rdata : 32'd0;
    assign d_rvalid = r_d_rvalid;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rd ? m_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter with a word memory model
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic [31:0] mem [0:262143];
    logic        poke_en = 1'b0;
    logic [17:0] poke_idx = '0;
    logic [31:0] poke_val = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [1:0]  exp_gnt;
        logic        exp_mwe;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        iq[$];
    rsp_t        dq[$];
    logic [31:0] ref_mem [0:15];
    bit          last_d, busy, i_pend, d_pend, exp_i, exp_d;

    mem_arbiter #(.MEM_ADDR_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory; bench preloads go through the same process.
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (m_we) mem[m_addr[19:2]] <= m_wdata;
        m_rdata <= mem[m_addr[19:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic poke(input logic [17:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic chk_ctl_zero(input string name);
        chk(name, 32'({i_gnt, d_gnt, m_we, i_rvalid, d_rvalid, i_err, d_err}), 32'd0);
        chk({name, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h0010_0000);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        if (r == 1) return 32'h0010_0000 << $urandom_range(0, 11);
        return 32'h200 + 4 * $urandom_range(0, 15);
    endfunction

    task automatic chk_rsp(input int c);
        bit ev;
        ev = (iq.size() > 0) && (iq[0].due == c);
        chk("rnd_i_rvalid", 32'(i_rvalid), 32'(ev));
        if (ev) begin
            chk("rnd_i_err", 32'(i_err), 32'(iq[0].err));
            chk("rnd_i_rdata", i_rdata, iq[0].rdata);
            void'(iq.pop_front());
        end
        ev = (dq.size() > 0) && (dq[0].due == c);
        chk("rnd_d_rvalid", 32'(d_rvalid), 32'(ev));
        if (ev) begin
            chk("rnd_d_err", 32'(d_err), 32'(dq[0].err));
            chk("rnd_d_rdata", d_rdata, dq[0].rdata);
            void'(dq.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[10];
        logic [31:0] val, mask, wd;
        int          wi;

        // Reset: everything quiet even with both ports requesting.
        rst_n = 1'b0;
        clr_inputs();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
        #12;
        chk_ctl_zero("reset_outs");

        // Contention straight out of reset: I, D, I, D.
        @(negedge clk);
        rst_n = 1'b1;
        clr_inputs();
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("rr_alt%0d", k), 32'({i_gnt, d_gnt}), (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        @(negedge clk);
        clr_inputs();
        repeat (2) @(negedge clk);

        // Instruction read with same-cycle grant and next-cycle data.
        poke(18'h40, 32'h1122_3344);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        chk("i_rd_gnt", 32'({i_gnt, d_gnt}), 32'd2);
        chk("i_rd_maddr", m_addr, 32'h100);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk("i_rd_rvalid", 32'({i_rvalid, d_rvalid}), 32'd2);
        chk("i_rd_rdata", i_rdata, 32'h1122_3344);

        // Partial write: read phase, merge phase blocking the i port, response at N+2.
        poke(18'h40, 32'hAABB_CCDD);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'h0000_1234;
        #1;
        chk("pw_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        chk("pw_read_mwe", 32'(m_we), 32'd0);
        @(negedge clk);
        clr_inputs();
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        chk("pw_merge_gnt", 32'({i_gnt, d_gnt}), 32'd0);
        chk("pw_merge_mwe", 32'(m_we), 32'd1);
        chk("pw_merge_addr", m_addr, 32'h100);
        chk("pw_merge_wdata", m_wdata, 32'hAABB_1234);
        chk("pw_merge_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        @(negedge clk);
        #1;
        chk("pw_rvalid", 32'({i_rvalid, d_rvalid}), 32'd1);
        chk("pw_rdata", d_rdata, 32'd0);
        chk("pw_i_gnt_after", 32'({i_gnt, d_gnt}), 32'd2);
        chk("pw_mem", mem[18'h40], 32'hAABB_1234);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk("pw_i_rdata", i_rdata, 32'hAABB_1234);

        // Single-transaction vectors, mostly error and boundary cases.
        poke(18'h40, 32'h1122_3344);
        poke(18'h3FFFF, 32'hCAFE_F00D);
        vt[0] = '{"i_rd_ok",     1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,        2'b10, 1'b0, 1'b0, 32'h1122_3344};
        vt[1] = '{"d_misalign",  1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0102, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0};
        vt[2] = '{"d_oor",       1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0010_0000, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0};
        vt[3] = '{"i_top_word",  1'b1, 32'h000F_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,        2'b10, 1'b0, 1'b0, 32'hCAFE_F00D};
        vt[4] = '{"i_misalign",  1'b1, 32'h0000_0101, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0};
        vt[5] = '{"d_be0_wr",    1'b0, 32'h0,         1'b1, 1'b1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 32'h0};
        vt[6] = '{"d_rd_after0", 1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 2'b01, 1'b0, 1'b0, 32'h1122_3344};
        vt[7] = '{"i_oor_high",  1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0};
        vt[8] = '{"d_wr_oor",    1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h0010_0004, 32'h1, 2'b01, 1'b0, 1'b1, 32'h0};
        vt[9] = '{"d_wr_misal",  1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h0000_0103, 32'h1, 2'b01, 1'b0, 1'b1, 32'h0};
        foreach (vt[k]) begin
            @(negedge clk);
            i_req = vt[k].ireq; i_addr = vt[k].iaddr;
            d_req = vt[k].dreq; d_we = vt[k].dwe; d_be = vt[k].dbe;
            d_addr = vt[k].daddr; d_wdata = vt[k].dwdata;
            #1;
            chk($sformatf("%s_gnt", vt[k].name), 32'({i_gnt, d_gnt}), 32'(vt[k].exp_gnt));
            chk($sformatf("%s_mwe", vt[k].name), 32'(m_we), 32'(vt[k].exp_mwe));
            @(negedge clk);
            clr_inputs();
            #1;
            chk($sformatf("%s_rvalid", vt[k].name), 32'({i_rvalid, d_rvalid}), 32'(vt[k].exp_gnt));
            chk($sformatf("%s_err", vt[k].name), 32'(vt[k].ireq ? i_err : d_err), 32'(vt[k].exp_err));
            chk($sformatf("%s_rdata", vt[k].name), vt[k].ireq ? i_rdata : d_rdata, vt[k].exp_rdata);
        end

        // Full write followed back-to-back by a read of the same word.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("fw_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        chk("fw_mwe", 32'(m_we), 32'd1);
        @(negedge clk);
        d_we = 1'b0; d_be = 4'h0;
        #1;
        chk("fw_wr_rvalid", 32'(d_rvalid), 32'd1);
        chk("fw_wr_rdata", d_rdata, 32'd0);
        chk("fw_rd_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        @(negedge clk);
        clr_inputs();
        #1;
        chk("fw_rd_rvalid", 32'(d_rvalid), 32'd1);
        chk("fw_rd_rdata", d_rdata, 32'hDEAD_BEEF);

        // Reset landing in the merge cycle aborts the write silently.
        poke(18'h41, 32'h5566_7788);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1000; d_addr = 32'h104; d_wdata = 32'hFF00_0000;
        #1;
        chk("abort_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        @(negedge clk);
        clr_inputs();
        #1;
        chk("abort_pre_mwe", 32'(m_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_ctl_zero("abort_outs");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("abort_no_rvalid%0d", k), 32'(d_rvalid), 32'd0);
            @(negedge clk);
        end
        chk("abort_mem", mem[18'h41], 32'h5566_7788);

        // Randomized traffic against a transaction-level reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 16; w++) begin
            val = $urandom;
            ref_mem[w] = val;
            poke(18'(32'h80 + w), val);
        end
        last_d = 1'b1; busy = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 1510; c++) begin
            @(negedge clk);
            if (!i_pend) begin
                i_req = (c < 1500) && ($urandom_range(0, 2) != 0);
                if (i_req) begin
                    i_addr = rnd_addr();
                    i_pend = 1'b1;
                end
            end
            if (!d_pend) begin
                d_req = (c < 1500) && ($urandom_range(0, 2) != 0);
                if (d_req) begin
                    d_we = 1'($urandom_range(0, 1));
                    wi = int'($urandom_range(0, 3));
                    d_be = (wi == 0) ? 4'h0 : (wi == 1) ? 4'hF : 4'($urandom_range(0, 15));
                    d_addr = rnd_addr();
                    d_wdata = $urandom;
                    d_pend = 1'b1;
                end
            end
            #1;
            chk_rsp(c);
            exp_i = 1'b0; exp_d = 1'b0;
            if (!busy) begin
                if (i_pend && d_pend) begin
                    exp_i = last_d;
                    exp_d = !last_d;
                end else begin
                    exp_i = i_pend;
                    exp_d = d_pend;
                end
            end
            chk("rnd_gnt", 32'({i_gnt, d_gnt}), 32'({exp_i, exp_d}));
            busy = 1'b0;
            if (exp_i) begin
                i_pend = 1'b0;
                last_d = 1'b0;
                if (addr_bad(i_addr)) iq.push_back('{c + 1, 1'b1, 32'd0});
                else iq.push_back('{c + 1, 1'b0, ref_mem[i_addr[5:2]]});
            end
            if (exp_d) begin
                d_pend = 1'b0;
                last_d = 1'b1;
                if (addr_bad(d_addr)) begin
                    dq.push_back('{c + 1, 1'b1, 32'd0});
                end else if (!d_we) begin
                    dq.push_back('{c + 1, 1'b0, ref_mem[d_addr[5:2]]});
                end else if (d_be == 4'h0) begin
                    dq.push_back('{c + 1, 1'b0, 32'd0});
                end else begin
                    mask = 32'd0;
                    for (int b = 0; b < 4; b++) if (d_be[b]) mask = mask + (32'hFF << (8 * b));
                    wd = ref_mem[d_addr[5:2]];
                    ref_mem[d_addr[5:2]] = (wd & ~mask) | (d_wdata & mask);
                    if (d_be == 4'hF) begin
                        dq.push_back('{c + 1, 1'b0, 32'd0});
                    end else begin
                        dq.push_back('{c + 2, 1'b0, 32'd0});
                        busy = 1'b1;
                    end
                end
            end
        end
        clr_inputs();
        chk("rnd_drained", 32'(iq.size() + dq.size()), 32'd0);
        for (int w = 0; w < 16; w++) begin
            chk($sformatf("rnd_mem%0d", w), mem[18'(32'h80 + w)], ref_mem[w]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
